// File: rtl/inv_char_seq.sv
// rtl/inv_char_seq.sv - Wishbone-run stimulus/capture sequencer for the analog inverter.
// Drives VIN through stim_o, samples synchronized VOUT and counts mismatches against ~VIN.
module inv_char_seq #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        stim_o,
   input  logic        resp_i,
   output logic        irq_o
);
   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;

   state_t                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic [31:0]            dat_q, dat_d;
   logic                   start_q, start_d, abort_q, abort_d;
   logic                   mode_q, mode_d;
   logic [15:0]            nsamp_q, nsamp_d;
   logic [7:0]             settle_q, settle_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic [15:0]            err_q, err_d, samp_q, samp_d, lfsr_q, lfsr_d;
   logic [8:0]             cnt_q, cnt_d;
   logic                   stim_q, stim_d, irq_q, irq_d;
   logic [SYNC_STAGES-1:0] sync_q;

   logic        req, wr;
   logic [2:0]  idx;
   logic        resp_s;
   logic [31:0] rdata;
   logic        unused_ok;

   assign req       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
   assign wr        = req & wbs_we_i;
   assign idx       = wbs_adr_i[4:2];
   assign resp_s    = sync_q[SYNC_STAGES-1];
   assign unused_ok = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign stim_o    = stim_q;
   assign irq_o     = irq_q;

   always_comb begin
      rdata = '0;
      case (idx)
         3'd0:    rdata = {30'd0, mode_q, 1'b0};
         3'd1:    rdata = {16'd0, nsamp_q};
         3'd2:    rdata = {24'd0, settle_q};
         3'd3:    rdata = {29'd0, done_q && (err_q == 16'd0), done_q, busy_q};
         3'd4:    rdata = {16'd0, err_q};
         3'd5:    rdata = {16'd0, samp_q};
         default: rdata = '0;
      endcase
   end

   // Bus side: one-cycle ack, lane-masked writes, START/ABORT as one-cycle pulses.
   always_comb begin
      ack_d    = req;
      dat_d    = (req && !wbs_we_i) ? rdata : 32'd0;
      start_d  = 1'b0;
      abort_d  = 1'b0;
      mode_d   = mode_q;
      nsamp_d  = nsamp_q;
      settle_d = settle_q;
      if (wr) begin
         if (idx == 3'd0 && wbs_sel_i[0]) begin
            mode_d  = wbs_dat_i[1];
            abort_d = wbs_dat_i[2];
            start_d = wbs_dat_i[0] & ~wbs_dat_i[2];
         end
         if (idx == 3'd1 && !busy_q) begin
            if (wbs_sel_i[0]) nsamp_d[7:0]  = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) nsamp_d[15:8] = wbs_dat_i[15:8];
         end
         if (idx == 3'd2 && !busy_q && wbs_sel_i[0]) settle_d = wbs_dat_i[7:0];
      end
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      samp_d  = samp_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      stim_d  = stim_q;
      irq_d   = 1'b0;
      if (abort_q) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         stim_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start_q) begin
               err_d   = '0;
               samp_d  = '0;
               done_d  = 1'b0;
               lfsr_d  = LFSR_SEED;
               stim_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = (nsamp_q == 16'd0) ? S_FINISH : S_DRIVE;
            end
            S_DRIVE: begin
               if (mode_q) begin
                  lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                  stim_d = lfsr_d[0];
               end else begin
                  stim_d = ~stim_q;
               end
               cnt_d   = {1'b0, settle_q} + 9'(SYNC_STAGES - 1);
               state_d = S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt_q == 9'd0) state_d = S_SAMPLE;
               else               cnt_d   = cnt_q - 9'd1;
            end
            S_SAMPLE: begin
               if (resp_s == stim_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
               samp_d  = samp_q + 16'd1;
               state_d = (samp_d == nsamp_q) ? S_FINISH : S_DRIVE;
            end
            S_FINISH: begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               irq_d   = 1'b1;
               stim_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q  <= S_IDLE;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         start_q  <= 1'b0;
         abort_q  <= 1'b0;
         mode_q   <= 1'b0;
         nsamp_q  <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= '0;
         samp_q   <= '0;
         lfsr_q   <= '0;
         cnt_q    <= '0;
         stim_q   <= 1'b0;
         irq_q    <= 1'b0;
         sync_q   <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         start_q  <= start_d;
         abort_q  <= abort_d;
         mode_q   <= mode_d;
         nsamp_q  <= nsamp_d;
         settle_q <= settle_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         samp_q   <= samp_d;
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         stim_q   <= stim_d;
         irq_q    <= irq_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], resp_i};
      end
   end
endmodule
